// File: rtl/tcdm_rr_arbiter_if.sv
// Bundles the requester-side and slave-side TCDM signals of tcdm_rr_arbiter.
// The arbiter connects through modport slave; the environment drives through modport master.
interface tcdm_rr_arbiter_if #(
   parameter int unsigned NR_MASTERS = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

   logic [NR_MASTERS-1:0]                 mst_req_i;
   logic [NR_MASTERS-1:0][ADDR_WIDTH-1:0] mst_add_i;
   logic [NR_MASTERS-1:0]                 mst_wen_i;
   logic [NR_MASTERS-1:0][DATA_WIDTH-1:0] mst_wdata_i;
   logic [NR_MASTERS-1:0][BE_WIDTH-1:0]   mst_be_i;
   logic [NR_MASTERS-1:0]                 mst_gnt_o;
   logic [NR_MASTERS-1:0]                 mst_r_valid_o;
   logic [DATA_WIDTH-1:0]                 mst_r_rdata_o;
   logic                                  mst_r_opc_o;

   logic                                  slv_req_o;
   logic [ADDR_WIDTH-1:0]                 slv_add_o;
   logic                                  slv_wen_o;
   logic [DATA_WIDTH-1:0]                 slv_wdata_o;
   logic [BE_WIDTH-1:0]                   slv_be_o;
   logic                                  slv_gnt_i;
   logic                                  slv_r_valid_i;
   logic [DATA_WIDTH-1:0]                 slv_r_rdata_i;
   logic                                  slv_r_opc_i;

   modport slave (
      input  mst_req_i, mst_add_i, mst_wen_i, mst_wdata_i, mst_be_i,
      input  slv_gnt_i, slv_r_valid_i, slv_r_rdata_i, slv_r_opc_i,
      output mst_gnt_o, mst_r_valid_o, mst_r_rdata_o, mst_r_opc_o,
      output slv_req_o, slv_add_o, slv_wen_o, slv_wdata_o, slv_be_o
   );

   modport master (
      output mst_req_i, mst_add_i, mst_wen_i, mst_wdata_i, mst_be_i,
      output slv_gnt_i, slv_r_valid_i, slv_r_rdata_i, slv_r_opc_i,
      input  mst_gnt_o, mst_r_valid_o, mst_r_rdata_o, mst_r_opc_o,
      input  slv_req_o, slv_add_o, slv_wen_o, slv_wdata_o, slv_be_o
   );
endinterface

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin TCDM arbiter with in-order ID FIFO for response routing.
// Optional per-master grant counters: define SOC_TCDM_ARB_PERF_CNT_EN.
module tcdm_rr_arbiter #(
   parameter int unsigned NR_MASTERS      = 4,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   tcdm_rr_arbiter_if.slave            bus,
   output logic                        err_o,
   output logic [NR_MASTERS-1:0][31:0] grant_cnt_o
);
   localparam int unsigned MW = $clog2(NR_MASTERS);
   localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
   localparam logic [PW-1:0] SLOT_END = PW'(MAX_OUTSTANDING - 1);
   localparam logic [MW-1:0] MST_END  = MW'(NR_MASTERS - 1);

   logic [MW-1:0] ptr_q, ptr_d;
   logic [MW-1:0] fifo_q [MAX_OUTSTANDING];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   logic [MW-1:0] win;
   logic          any_req, slv_req, hs, pop;

   // Scan from ptr with wrap; the first requester found wins.
   always_comb begin
      int unsigned j;
      win     = '0;
      any_req = 1'b0;
      for (int unsigned i = 0; i < NR_MASTERS; i++) begin
         j = 32'(ptr_q) + i;
         if (j >= NR_MASTERS) j = j - NR_MASTERS;
         if (!any_req && bus.mst_req_i[MW'(j)]) begin
            any_req = 1'b1;
            win     = MW'(j);
         end
      end
   end

   assign slv_req = any_req & (cnt_q < CNT_MAX) & ~rst_i;
   assign hs      = slv_req & bus.slv_gnt_i;
   assign pop     = bus.slv_r_valid_i & (cnt_q != '0) & ~rst_i;

   always_comb begin
      bus.slv_req_o     = slv_req;
      bus.slv_add_o     = '0;
      bus.slv_wen_o     = 1'b0;
      bus.slv_wdata_o   = '0;
      bus.slv_be_o      = '0;
      bus.mst_gnt_o     = '0;
      bus.mst_r_valid_o = '0;
      bus.mst_r_rdata_o = '0;
      bus.mst_r_opc_o   = 1'b0;
      if (any_req && !rst_i) begin
         bus.slv_add_o   = bus.mst_add_i[win];
         bus.slv_wen_o   = bus.mst_wen_i[win];
         bus.slv_wdata_o = bus.mst_wdata_i[win];
         bus.slv_be_o    = bus.mst_be_i[win];
      end
      if (hs) bus.mst_gnt_o[win] = 1'b1;
      if (pop) bus.mst_r_valid_o[fifo_q[rd_q]] = 1'b1;
      if (!rst_i) begin
         bus.mst_r_rdata_o = bus.slv_r_rdata_i;
         bus.mst_r_opc_o   = bus.slv_r_opc_i;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      err_d = err_q | (bus.slv_r_valid_i & (cnt_q == '0));
      if (hs) begin
         ptr_d = (win == MST_END) ? '0 : win + 1'b1;
         wr_d  = (wr_q == SLOT_END) ? '0 : wr_q + 1'b1;
      end
      if (pop) rd_d = (rd_q == SLOT_END) ? '0 : rd_q + 1'b1;
      if (hs && !pop) cnt_d = cnt_q + 1'b1;
      else if (pop && !hs) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
      end else begin
         ptr_q <= ptr_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
         if (hs) fifo_q[wr_q] <= win;
      end
   end

   assign err_o = err_q;

`ifdef SOC_TCDM_ARB_PERF_CNT_EN
   logic [NR_MASTERS-1:0][31:0] gcnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         gcnt_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NR_MASTERS; i++) begin
            if (hs && (win == MW'(i)) && (gcnt_q[i] != '1)) gcnt_q[i] <= gcnt_q[i] + 32'd1;
         end
      end
   end

   assign grant_cnt_o = gcnt_q;
`else
   assign grant_cnt_o = '0;
`endif
endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// Directed bench for tcdm_rr_arbiter: queue-based reference model checked every cycle,
// plus literal expectations for grant order, stall behaviour, error flag and counters.
module tb_tcdm_rr_arbiter;
   localparam int unsigned NM = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned MO = 2;
   localparam int unsigned BW = DW / 8;

   logic                clk_i = 1'b0;
   logic                rst_i;
   logic                err_o;
   logic [NM-1:0][31:0] grant_cnt_o;

   tcdm_rr_arbiter_if #(.NR_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   tcdm_rr_arbiter #(
      .NR_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .bus(bus), .err_o(err_o), .grant_cnt_o(grant_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int lat      = 1;
   bit force_rv = 1'b0;

   int          m_q[$];
   int          m_ptr = 0;
   bit          m_err = 1'b0;
   int unsigned m_cnt[NM];

   int          due[$];
   logic [NM-1:0] gnt_log[$];
   logic [NM-1:0] rv_log[$];
   logic          req_log[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_gcnt(input int i);
`ifdef SOC_TCDM_ARB_PERF_CNT_EN
      return m_cnt[i];
`else
      return (i < 0) ? 32'd1 : 32'd0;
`endif
   endfunction

   task automatic compare();
      int            win;
      bit            any, sreq, hs;
      logic [NM-1:0] eg, erv;
      if (rst_i) begin
         m_q.delete();
         m_ptr = 0;
         m_err = 1'b0;
         for (int i = 0; i < NM; i++) m_cnt[i] = 0;
         chk("rst_slv_req", bus.slv_req_o, 0);
         chk("rst_slv_add", bus.slv_add_o, 0);
         chk("rst_gnt", bus.mst_gnt_o, 0);
         chk("rst_rvalid", bus.mst_r_valid_o, 0);
         chk("rst_rdata", bus.mst_r_rdata_o, 0);
         chk("rst_err", err_o, 0);
         for (int i = 0; i < NM; i++) chk("rst_gcnt", grant_cnt_o[i], 0);
         return;
      end
      any = 1'b0;
      win = 0;
      for (int k = 0; k < NM; k++) begin
         int j = (m_ptr + k) % NM;
         if (!any && bus.mst_req_i[j]) begin any = 1'b1; win = j; end
      end
      sreq = any && (m_q.size() < MO);
      hs   = sreq && bus.slv_gnt_i;
      eg   = '0;
      if (hs) eg[win] = 1'b1;
      erv  = '0;
      if (bus.slv_r_valid_i && m_q.size() > 0) erv[m_q[0]] = 1'b1;

      chk("slv_req", bus.slv_req_o, sreq);
      chk("slv_add", bus.slv_add_o, any ? bus.mst_add_i[win] : '0);
      chk("slv_wen", bus.slv_wen_o, any ? bus.mst_wen_i[win] : 1'b0);
      chk("slv_wdata", bus.slv_wdata_o, any ? bus.mst_wdata_i[win] : '0);
      chk("slv_be", bus.slv_be_o, any ? bus.mst_be_i[win] : '0);
      chk("mst_gnt", bus.mst_gnt_o, eg);
      chk("mst_rvalid", bus.mst_r_valid_o, erv);
      chk("mst_rdata", bus.mst_r_rdata_o, bus.slv_r_rdata_i);
      chk("mst_opc", bus.mst_r_opc_o, bus.slv_r_opc_i);
      chk("err", err_o, m_err);
      for (int i = 0; i < NM; i++) chk("gcnt", grant_cnt_o[i], exp_gcnt(i));

      if (bus.slv_r_valid_i) begin
         if (m_q.size() == 0) m_err = 1'b1;
         else void'(m_q.pop_front());
      end
      if (hs) begin
         m_q.push_back(win);
         m_ptr = (win + 1) % NM;
         if (m_cnt[win] != 32'hFFFF_FFFF) m_cnt[win]++;
      end
   endtask

   task automatic step();
      bus.slv_r_valid_i = 1'b0;
      bus.slv_r_rdata_i = '0;
      bus.slv_r_opc_i   = 1'b0;
      if (force_rv || (due.size() > 0 && due[0] == cyc)) begin
         if (!force_rv) void'(due.pop_front());
         bus.slv_r_valid_i = 1'b1;
         bus.slv_r_rdata_i = $urandom;
         bus.slv_r_opc_i   = 1'($urandom_range(0, 1));
      end
      #2;
      compare();
      gnt_log.push_back(bus.mst_gnt_o);
      rv_log.push_back(bus.mst_r_valid_o);
      req_log.push_back(bus.slv_req_o);
      if (bus.slv_req_o && bus.slv_gnt_i) due.push_back(cyc + lat);
      @(negedge clk_i);
      cyc++;
   endtask

   task automatic clear_logs();
      gnt_log.delete();
      rv_log.delete();
      req_log.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i             = 1'b1;
      bus.mst_req_i     = '0;
      bus.slv_gnt_i     = 1'b0;
      bus.slv_r_valid_i = 1'b0;
      bus.slv_r_rdata_i = '0;
      bus.slv_r_opc_i   = 1'b0;
      for (int i = 0; i < NM; i++) begin
         bus.mst_add_i[i]   = 32'h1000_0000 + 32'(i) * 32'h100;
         bus.mst_wen_i[i]   = 1'(i % 2);
         bus.mst_wdata_i[i] = 32'hD000_0000 + 32'(i);
         bus.mst_be_i[i]    = BW'(1 << i);
      end
      @(negedge clk_i);
      step(); step();
      rst_i = 1'b0;

      // All masters requesting, 1-cycle slave latency
      lat = 1; bus.slv_gnt_i = 1'b1; bus.mst_req_i = 4'hF;
      clear_logs();
      repeat (8) step();
      bus.mst_req_i = '0;
      step(); step();
      for (int k = 0; k < 8; k++) begin
         chk("t1_order", gnt_log[k], 4'b0001 << (k % 4));
         chk("t1_resp", rv_log[k + 1], 4'b0001 << (k % 4));
      end

      // Lone master 2 while ptr sits at 3
      clear_logs();
      bus.mst_req_i = 4'b0100; step(); step();
      bus.mst_req_i = 4'b1111; step();
      bus.mst_req_i = '0; step(); step();
      chk("t2_lone", gnt_log[1], 4'b0100);
      chk("t2_ptr3", gnt_log[2], 4'b1000);

      // Slave latency 4 saturates the outstanding window
      lat = 4; clear_logs();
      bus.mst_req_i = 4'hF;
      repeat (12) step();
      bus.mst_req_i = '0;
      repeat (6) step();
      chk("t3_req0", req_log[0], 1); chk("t3_req1", req_log[1], 1);
      chk("t3_req2", req_log[2], 0); chk("t3_req3", req_log[3], 0);
      chk("t3_req4", req_log[4], 0); chk("t3_req5", req_log[5], 1);

      // Stalled grant keeps the winner
      lat = 1;
      bus.mst_req_i = 4'b0001; step();
      bus.mst_req_i = '0; step();
      clear_logs();
      bus.mst_req_i = 4'b1010; bus.slv_gnt_i = 1'b0;
      repeat (3) step();
      bus.slv_gnt_i = 1'b1; step(); step();
      bus.mst_req_i = '0; step(); step();
      chk("t4_stall", gnt_log[0] | gnt_log[1] | gnt_log[2], 0);
      chk("t4_held", req_log[2], 1);
      chk("t4_first", gnt_log[3], 4'b0010);
      chk("t4_next", gnt_log[4], 4'b1000);

      // Response with nothing outstanding
      clear_logs();
      force_rv = 1'b1; step(); force_rv = 1'b0;
      chk("t5_norv", rv_log[0], 0);
      chk("t5_err_rise", err_o, 1);
      repeat (3) step();
      chk("t5_err_hold", err_o, 1);
      rst_i = 1'b1; step(); rst_i = 1'b0;
      chk("t5_err_clr", err_o, 0);

      // Grant counters, then reset with transactions in flight
      lat = 1;
      bus.mst_req_i = 4'b0001; repeat (10) step();
      bus.mst_req_i = 4'b0010; repeat (5) step();
      bus.mst_req_i = '0; step(); step();
`ifdef SOC_TCDM_ARB_PERF_CNT_EN
      chk("t6_cnt0", grant_cnt_o[0], 10);
      chk("t6_cnt1", grant_cnt_o[1], 5);
`else
      chk("t6_cnt0", grant_cnt_o[0], 0);
      chk("t6_cnt1", grant_cnt_o[1], 0);
`endif
      lat = 3;
      bus.mst_req_i = 4'b0001; step(); step(); step();
      rst_i = 1'b1; step(); rst_i = 1'b0;
      bus.mst_req_i = '0;
      chk("t6_rst_cnt", grant_cnt_o[0], 0);
      chk("t6_rst_err", err_o, 0);
      step();
      chk("t6_late_err", err_o, 1);
      clear_logs();
      lat = 1; bus.mst_req_i = 4'hF; step();
      bus.mst_req_i = '0; step(); step();
      chk("t6_ptr_rst", gnt_log[0], 4'b0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
